// File: rtl/svga_timing_gen.sv
// SVGA 800x600 @72 Hz raster timing: col/row counters, decoded sync/blank levels, frame/vblank strobes.
// Optional 16-bit frame counter enabled by defining SVGA_FRAME_COUNT_EN.
module svga_timing_gen #(
   parameter int   H_VISIBLE   = 800,
   parameter int   H_FRONT     = 56,
   parameter int   H_SYNC      = 120,
   parameter int   H_BACK      = 64,
   parameter int   V_VISIBLE   = 600,
   parameter int   V_FRONT     = 37,
   parameter int   V_SYNC      = 6,
   parameter int   V_BACK      = 23,
   parameter logic SYNC_ACTIVE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   output logic [10:0] col,
   output logic [9:0]  row,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]  VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [10:0] col_reg;
   logic [9:0]  row_reg;
   logic        col_wrap;
   logic        row_wrap;

   assign col_wrap = (col_reg == H_LAST);
   assign row_wrap = (row_reg == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (pix_en) begin
         if (col_wrap) begin
            col_reg <= '0;
            row_reg <= row_wrap ? 10'd0 : row_reg + 10'd1;
         end else begin
            col_reg <= col_reg + 11'd1;
         end
      end
   end

`ifdef SVGA_FRAME_COUNT_EN
   logic [15:0] frame_count_reg;

   // Counts completed frames: advances on the (last,last) -> (0,0) edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_count_reg <= '0;
      else if (pix_en && col_wrap && row_wrap)
         frame_count_reg <= frame_count_reg + 16'd1;
   end

   assign frame_count = frame_count_reg;
`else
   assign frame_count = 16'd0;
`endif

   assign col = col_reg;
   assign row = row_reg;

   // Decoded levels are combinational from the live counters; pulses are additionally gated by pix_en.
   assign blank        = (col_reg >= H_VIS) | (row_reg >= V_VIS);
   assign hs           = ((col_reg >= HS_BEGIN) && (col_reg < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vs           = ((row_reg >= VS_BEGIN) && (row_reg < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign frame_start  = pix_en && (col_reg == 11'd0) && (row_reg == 10'd0);
   assign vblank_start = pix_en && (col_reg == 11'd0) && (row_reg == V_VIS);

endmodule

// File: doc/svga_timing_gen.md
Name: svga_timing_gen

Overview:
- Generates SVGA 800x600 @72 Hz raster timing: pixel column/row counters, hsync, vsync, blank, and frame/vblank strobes.
- Sits directly upstream of the pixel-colour logic, which compares col/row against the playfield, border, next, hold, lines, timer and pending regions.
- Also sits upstream of the VGA output pins.
- Its vblank strobe is the per-frame tick that game logic uses to commit display state between frames.

Parameters:
- H_VISIBLE, 800, active pixels per line (equals SVGA_WIDTH)
- H_FRONT, 56, horizontal front porch in pixels
- H_SYNC, 120, hsync pulse width in pixels
- H_BACK, 64, horizontal back porch in pixels
- V_VISIBLE, 600, active lines per frame (equals SVGA_HEIGHT)
- V_FRONT, 37, vertical front porch in lines
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 23, vertical back porch in lines
- SYNC_ACTIVE, 1, level driven on hs/vs during the sync pulse
- Derived constants (not overridable):
  - H_TOTAL = 1040
  - V_TOTAL = 666
  - H_TOTAL*V_TOTAL = 692640 cycles per frame at 50 MHz

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel strobe; counters advance only when high (tie to 1 for a 50 MHz pixel clock)
- col  out  11  current column, 0..H_TOTAL-1
- row  out  10  current row, 0..V_TOTAL-1
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- blank  out  1  high outside the visible 800x600 window
- frame_start  out  1  one-cycle pulse at the start of each frame
- vblank_start  out  1  one-cycle pulse at the start of vertical blanking
- frame_count  out  16  frame counter (optional feature)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - col=0, row=0, frame_count=0.
  - Decoded outputs then follow from (0,0): hs=vs=~SYNC_ACTIVE, blank=0, frame_start=0, vblank_start=0.
- Counter register:
  - col and row are the registered counters themselves; there is no extra output register.
- Column counter, on a rising clk with pix_en=1:
  - col increments by 1.
  - At col==H_TOTAL-1, col wraps to 0 and the row counter steps.
- Row counter, stepping on each col wrap:
  - row increments by 1.
  - At row==V_TOTAL-1, row wraps to 0.
  - The simultaneous wrap of col==1039 and row==665 takes both counters to (0,0) on the same edge.
- pix_en=0: col, row and frame_count hold. All pulses are 0 that cycle; the decoded levels hs/vs/blank remain valid.
- Decoded outputs are combinational from the current col/row (zero latency, same cycle as the counter value):
  - blank = (col >= H_VISIBLE) | (row >= V_VISIBLE)
  - hs = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= col < H_VISIBLE+H_FRONT+H_SYNC (856..975), else ~SYNC_ACTIVE
  - vs = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (637..642), else ~SYNC_ACTIVE
  - hs is independent of row; hsync continues during vertical blanking.
- Pulses:
  - frame_start = pix_en & (col==0) & (row==0)
  - vblank_start = pix_en & (col==0) & (row==V_VISIBLE)
  - Each fires exactly once per frame, and never in the same cycle as the other.
- Reset deasserted mid-frame restarts the raster at (0,0). The first frame_start occurs on the first pix_en cycle after reset release.
- Widths:
  - Counters compare using the full 11-bit/10-bit widths.
  - Counters never exceed H_TOTAL-1 / V_TOTAL-1.
  - No out-of-range values are reachable from reset.

Optional Feature:
- Macro: SVGA_FRAME_COUNT_EN
- Defined:
  - frame_count is a 16-bit register incremented on the edge where the counters wrap from (1039,665) to (0,0) with pix_en=1.
  - It wraps 65535 to 0.
  - It is consumed by the frames display region.
- Undefined: frame_count is tied to 16'd0 and no register is inferred.

Test Plan:
- Release rst with pix_en=1:
  - col=0,row=0,blank=0,hs=vs=0, and frame_start=1 in that first cycle.
  - After 1040 cycles: col=0,row=1.
  - After 692640 cycles: back to (0,0) with frame_start=1 again.
- Sync timing, scanning row 0:
  - hs=1 exactly for col 856..975 (120 cycles); blank=1 for col 800..1039.
  - vs=1 exactly for rows 637..642; blank=1 for all col in rows 600..665.
- Pulse uniqueness, over 3 full frames:
  - frame_start count=3 and vblank_start count=3.
  - vblank_start occurs at (0,600), 624000 cycles after frame_start.
- pix_en gating:
  - Toggle pix_en 1/0 every cycle; one frame takes 1385280 clk cycles.
  - col/row hold on pix_en=0 cycles, with no pulses on those cycles.
- Async reset mid-frame:
  - Assert rst at (500,300) between clock edges; col/row read 0 before the next clk edge.
  - After release, the raster resumes from (0,0).
- With SVGA_FRAME_COUNT_EN:
  - After 5 frames, frame_count=5.
  - Forcing frame_count=65535, the next wrap gives 0.
  - Without the macro, frame_count stays 0 throughout.
